lfsr_burst_gen: RTL and testbench
=================================

// Module: lfsr_burst_gen
// PURPOSE
//  Parametrised Fibonacci XNOR LFSR pattern generator. Adds the following over the single-width, single-step generator:
//   - selectable polynomial and multi-bit advance per clock
//   - run-time seed load
//   - free-run and counted-burst modes
//   - period-wrap detection with a period counter
//  Feeds PRBS data to downstream test/scrambler logic.
// PARAMETERS
//  NUM_BITS     16        LFSR width, 3..32
//  TAPS         16'hD008  feedback mask; bit i set => state[i] in XNOR (default x^16+x^15+x^13+x^4+1)
//  STEPS        1         LFSR iterations per advance, 1..NUM_BITS (combinationally unrolled)
//  SEED_DEFAULT 0         reset/fallback state; must not be all-ones
//  LEN_BITS     16        width of burst length
// PORTS
//  i_Clk          in   1         clock, rising edge
//  i_Rst_n        in   1         async reset, active low
//  i_Enable       in   1         advance permission (free-run) / stall when low (burst)
//  i_Mode         in   1         0 = free-run, 1 = burst
//  i_Start        in   1         burst start pulse, sampled in IDLE only
//  i_Burst_Len    in   LEN_BITS  advances per burst, latched on accepted start
//  i_Seed_DV      in   1         seed load strobe
//  i_Seed_Data    in   NUM_BITS  seed value
//  o_LFSR_Data    out  NUM_BITS  current state
//  o_LFSR_DV      out  1         high the cycle after an advance (o_LFSR_Data is new)
//  o_LFSR_Done    out  1         1-cycle pulse: state after advance equals reference seed
//  o_Period_Cnt   out  NUM_BITS  advances since last seed load or wrap
//  o_Busy         out  1         high in BURST
//  o_Burst_Done   out  1         1-cycle pulse at burst completion
//  o_Seed_Err     out  1         1-cycle pulse: illegal seed replaced
// BEHAVIOUR
//  Reset: state=ref=SEED_DEFAULT, FSM=IDLE; all other outputs 0. Async assert, sync-safe deassert.
//  Single iteration: fb = ~^(state & TAPS); state <= {state[NUM_BITS-2:0], fb}.
//    Lock state (all-ones) never occurs from a legal state.
//  Advance = STEPS iterations in one clock. Latency: advance at edge k, o_LFSR_DV/new data visible after k.
//  Priority per cycle: i_Seed_DV > i_Start > i_Enable.
//  Seed load, any state:
//    - state <= i_Seed_Data; ref <= same; o_Period_Cnt <= 0; FSM -> IDLE.
//    - Aborts an active burst with no o_Burst_Done. No advance that cycle.
//  FSM IDLE:
//    - i_Mode=0 & i_Enable: advance every cycle.
//    - i_Mode=1 & i_Start: latch len, go BURST (no advance that cycle).
//    - Latched len=0: go DONE directly.
//  FSM BURST: o_Busy=1.
//    - Advance each cycle i_Enable=1; decrement remaining.
//    - Last advance -> DONE. i_Start ignored. i_Mode change is ignored until IDLE.
//  FSM DONE: o_Burst_Done=1 for exactly one cycle, no advance, -> IDLE.
//  Wrap: o_LFSR_Done pulses and o_Period_Cnt clears to 0 when post-advance state == ref.
//    - Otherwise o_Period_Cnt +1 per advance, wraps modulo 2^NUM_BITS.
//    - With STEPS>1 a wrap is seen only if landing exactly on ref.
//  Reset mid-burst: immediate return to reset values; no done pulse.
// CONFIGURATION
//  LFSR_SEED_CHECK_EN defined:
//    - A seed equal to all-ones (lock state) loads SEED_DEFAULT into state and ref.
//    - o_Seed_Err pulses one cycle.
//  Not defined:
//    - Seed loaded verbatim; an all-ones seed locks the LFSR (state constant, advances still counted).
//    - o_Seed_Err tied 0.
// TESTING
//  1 NUM_BITS=4,TAPS=4'hC: reset, i_Mode=0,i_Enable=1
//      -> data 0,1,3,7,E...; o_LFSR_Done on 15th advance; o_Period_Cnt 1..14 then 0.
//  2 Default 16-bit free-run 65535 advances -> single o_LFSR_Done, data back to 16'h0000.
//  3 i_Mode=1, i_Burst_Len=5, i_Start, i_Enable toggled 1,0,1,1,1,1
//      -> exactly 5 o_LFSR_DV; o_Busy 7 cycles; o_Burst_Done one cycle after last advance.
//  4 i_Seed_DV=1, i_Seed_Data=16'h1234 during burst
//      -> next cycle data=16'h1234, o_Busy=0, no o_Burst_Done, o_Period_Cnt=0.
//  5 Seed 16'hFFFF with LFSR_SEED_CHECK_EN -> data=16'h0000, o_Seed_Err pulse.
//      Without the macro -> data stays 16'hFFFF.
//  6 STEPS=4, NUM_BITS=4 free-run from 0 -> data 0,E,...; i_Rst_n low mid-run -> all outputs reset asynchronously.

Source files
------------

// File: rtl/lfsr_burst_gen_if.sv
// lfsr_burst_gen_if: control and data bundle of the LFSR burst generator.
// Master drives seed/burst controls; slave is the generator itself.
interface lfsr_burst_gen_if #(
    parameter int unsigned NUM_BITS = 16,
    parameter int unsigned LEN_BITS = 16
);
    logic                i_Enable;
    logic                i_Mode;
    logic                i_Start;
    logic [LEN_BITS-1:0] i_Burst_Len;
    logic                i_Seed_DV;
    logic [NUM_BITS-1:0] i_Seed_Data;
    logic [NUM_BITS-1:0] o_LFSR_Data;
    logic                o_LFSR_DV;
    logic                o_LFSR_Done;
    logic [NUM_BITS-1:0] o_Period_Cnt;
    logic                o_Busy;
    logic                o_Burst_Done;
    logic                o_Seed_Err;

    modport master (
        output i_Enable, i_Mode, i_Start, i_Burst_Len,
        output i_Seed_DV, i_Seed_Data,
        input  o_LFSR_Data, o_LFSR_DV, o_LFSR_Done,
        input  o_Period_Cnt, o_Busy, o_Burst_Done, o_Seed_Err
    );

    modport slave (
        input  i_Enable, i_Mode, i_Start, i_Burst_Len,
        input  i_Seed_DV, i_Seed_Data,
        output o_LFSR_Data, o_LFSR_DV, o_LFSR_Done,
        output o_Period_Cnt, o_Busy, o_Burst_Done, o_Seed_Err
    );
endinterface

// File: rtl/lfsr_burst_gen.sv
// lfsr_burst_gen: Fibonacci XNOR LFSR with multi-step advance and bursts.
// Define LFSR_SEED_CHECK_EN to replace an all-ones seed with SEED_DEFAULT.
module lfsr_burst_gen #(
    parameter int unsigned         NUM_BITS     = 16,
    parameter logic [NUM_BITS-1:0] TAPS         = 16'hD008,
    parameter int unsigned         STEPS        = 1,
    parameter logic [NUM_BITS-1:0] SEED_DEFAULT = '0,
    parameter int unsigned         LEN_BITS     = 16
) (
    input logic                i_Clk,
    input logic                i_Rst_n,
    lfsr_burst_gen_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DONE
    } state_t;

    localparam logic [LEN_BITS-1:0] LEN_ONE = LEN_BITS'(1);
    localparam logic [NUM_BITS-1:0] CNT_ONE = NUM_BITS'(1);

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] lfsr_q, lfsr_d;
    logic [NUM_BITS-1:0] ref_q, ref_d;
    logic [NUM_BITS-1:0] cnt_q, cnt_d;
    logic [LEN_BITS-1:0] rem_q, rem_d;
    logic                dv_q, dv_d;
    logic                done_q, done_d;
    logic                serr_q, serr_d;
    logic [NUM_BITS-1:0] adv_val;
    logic [NUM_BITS-1:0] seed_val;
    logic                seed_bad;
    logic                adv;

`ifdef LFSR_SEED_CHECK_EN
    assign seed_bad = &bus.i_Seed_Data;
`else
    assign seed_bad = 1'b0;
`endif
    assign seed_val = seed_bad ? SEED_DEFAULT : bus.i_Seed_Data;

    // STEPS shift iterations unrolled into one combinational advance
    always_comb begin
        adv_val = lfsr_q;
        for (int i = 0; i < int'(STEPS); i++) begin
            adv_val = {adv_val[NUM_BITS-2:0], ~^(adv_val & TAPS)};
        end
    end

    // Seed load beats burst start, which beats a plain advance
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        ref_d   = ref_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dv_d    = 1'b0;
        done_d  = 1'b0;
        serr_d  = 1'b0;
        adv     = 1'b0;
        if (bus.i_Seed_DV) begin
            lfsr_d  = seed_val;
            ref_d   = seed_val;
            cnt_d   = '0;
            serr_d  = seed_bad;
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.i_Mode && bus.i_Start) begin
                        rem_d   = bus.i_Burst_Len;
                        state_d = (bus.i_Burst_Len == '0) ? S_DONE : S_BURST;
                    end else if (!bus.i_Mode && bus.i_Enable) begin
                        adv = 1'b1;
                    end
                end
                S_BURST: begin
                    if (bus.i_Enable) begin
                        adv   = 1'b1;
                        rem_d = rem_q - LEN_ONE;
                        if (rem_q == LEN_ONE) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
            if (adv) begin
                lfsr_d = adv_val;
                dv_d   = 1'b1;
                if (adv_val == ref_q) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end
    end

    // State, pattern and status registers
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_DEFAULT;
            ref_q   <= SEED_DEFAULT;
            cnt_q   <= '0;
            rem_q   <= '0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            ref_q   <= ref_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
            serr_q  <= serr_d;
        end
    end

    // Busy spans the burst and its completion cycle
    assign bus.o_LFSR_Data  = lfsr_q;
    assign bus.o_LFSR_DV    = dv_q;
    assign bus.o_LFSR_Done  = done_q;
    assign bus.o_Period_Cnt = cnt_q;
    assign bus.o_Busy       = (state_q != S_IDLE);
    assign bus.o_Burst_Done = (state_q == S_DONE);
    assign bus.o_Seed_Err   = serr_q;
endmodule

// File: tb/tb_lfsr_burst_gen.sv
// tb_lfsr_burst_gen: directed bench for lfsr_burst_gen.
// Three instances: 16-bit default, 4-bit single step, 4-bit four step.
module tb_lfsr_burst_gen;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    lfsr_burst_gen_if #(.NUM_BITS(16), .LEN_BITS(16)) u16 ();
    lfsr_burst_gen_if #(.NUM_BITS(4), .LEN_BITS(16))  u4 ();
    lfsr_burst_gen_if #(.NUM_BITS(4), .LEN_BITS(16))  u4s ();

    lfsr_burst_gen dut16 (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (u16)
    );

    lfsr_burst_gen #(
        .NUM_BITS(4), .TAPS(4'hC), .STEPS(1),
        .SEED_DEFAULT(4'h0), .LEN_BITS(16)
    ) dut4 (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (u4)
    );

    lfsr_burst_gen #(
        .NUM_BITS(4), .TAPS(4'hC), .STEPS(4),
        .SEED_DEFAULT(4'h0), .LEN_BITS(16)
    ) dut4s (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (u4s)
    );

    typedef struct packed {
        logic [31:0] st;
        logic [31:0] rf;
        logic [31:0] cnt;
        logic [31:0] rem;
        logic        fin;
        logic        dv;
        logic        done;
        logic        serr;
    } mdl_t;

    localparam mdl_t M_RST = '0;

    mdl_t m16, m4, m4s;

    function automatic logic [31:0] mask_of(int nb);
        return (nb >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
    endfunction

    function automatic logic [31:0] step_n(logic [31:0] s, logic [31:0] taps,
                                           int nb, int n);
        logic [31:0] r;
        r = s;
        for (int k = 0; k < n; k++) begin
            r = ((r << 1) | {31'd0, ~^(r & taps)}) & mask_of(nb);
        end
        return r;
    endfunction

    // One clock of the generator seen as seed / burst / free-run rules
    function automatic mdl_t mdl_next(mdl_t m, logic sdv, logic [31:0] sdata,
                                      logic start, logic mode, logic en,
                                      logic [31:0] len, int nb,
                                      logic [31:0] taps, int steps,
                                      logic [31:0] sdef);
        mdl_t        n;
        logic        adv;
        logic [31:0] v;
        n      = m;
        adv    = 1'b0;
        n.dv   = 1'b0;
        n.done = 1'b0;
        n.serr = 1'b0;
        if (sdv) begin
            v = sdata;
`ifdef LFSR_SEED_CHECK_EN
            if (sdata == mask_of(nb)) begin
                v      = sdef;
                n.serr = 1'b1;
            end
`endif
            n.st  = v;
            n.rf  = v;
            n.cnt = 0;
            n.rem = 0;
            n.fin = 1'b0;
        end else if (m.fin) begin
            n.fin = 1'b0;
        end else if (m.rem != 0) begin
            if (en) begin
                adv   = 1'b1;
                n.rem = m.rem - 1;
                n.fin = (n.rem == 0);
            end
        end else if (mode && start) begin
            n.rem = len;
            n.fin = (len == 0);
        end else if (!mode && en) begin
            adv = 1'b1;
        end
        if (adv) begin
            n.st = step_n(m.st, taps, nb, steps);
            n.dv = 1'b1;
            if (n.st == m.rf) begin
                n.done = 1'b1;
                n.cnt  = 0;
            end else begin
                n.cnt = (m.cnt + 1) & mask_of(nb);
            end
        end
        return n;
    endfunction

    function automatic logic [69:0] pk(logic [31:0] d, logic dv, logic dn,
                                       logic [31:0] c, logic b, logic bd,
                                       logic se);
        return {d, dv, dn, c, b, bd, se};
    endfunction

    function automatic logic [69:0] pk_m(mdl_t m);
        return pk(m.st, m.dv, m.done, m.cnt, (m.rem != 0) || m.fin,
                  m.fin, m.serr);
    endfunction

    task automatic chk(string name, logic [69:0] act, logic [69:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference models follow the same clock and reset as the DUTs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m16 <= M_RST;
            m4  <= M_RST;
            m4s <= M_RST;
        end else begin
            m16 <= mdl_next(m16, u16.i_Seed_DV, 32'(u16.i_Seed_Data),
                            u16.i_Start, u16.i_Mode, u16.i_Enable,
                            32'(u16.i_Burst_Len), 16, 32'hD008, 1, 32'h0);
            m4  <= mdl_next(m4, u4.i_Seed_DV, 32'(u4.i_Seed_Data),
                            u4.i_Start, u4.i_Mode, u4.i_Enable,
                            32'(u4.i_Burst_Len), 4, 32'hC, 1, 32'h0);
            m4s <= mdl_next(m4s, u4s.i_Seed_DV, 32'(u4s.i_Seed_Data),
                            u4s.i_Start, u4s.i_Mode, u4s.i_Enable,
                            32'(u4s.i_Burst_Len), 4, 32'hC, 4, 32'h0);
        end
    end

    // Every-cycle comparison against the models
    always @(negedge clk) begin
        chk("cyc16", pk(32'(u16.o_LFSR_Data), u16.o_LFSR_DV, u16.o_LFSR_Done,
                        32'(u16.o_Period_Cnt), u16.o_Busy, u16.o_Burst_Done,
                        u16.o_Seed_Err), pk_m(m16));
        chk("cyc4", pk(32'(u4.o_LFSR_Data), u4.o_LFSR_DV, u4.o_LFSR_Done,
                       32'(u4.o_Period_Cnt), u4.o_Busy, u4.o_Burst_Done,
                       u4.o_Seed_Err), pk_m(m4));
        chk("cyc4s", pk(32'(u4s.o_LFSR_Data), u4s.o_LFSR_DV, u4s.o_LFSR_Done,
                        32'(u4s.o_Period_Cnt), u4s.o_Busy, u4s.o_Burst_Done,
                        u4s.o_Seed_Err), pk_m(m4s));
    end

    logic [3:0] seq4 [15] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                              4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8,
                              4'h0};
    logic       en_pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        int ndone;
        int dv_n;
        int busy_n;
        int bd_n;
        int last_dv;
        int bd_at;
        u16.i_Enable = 0; u16.i_Mode = 0; u16.i_Start = 0;
        u16.i_Burst_Len = '0; u16.i_Seed_DV = 0; u16.i_Seed_Data = '0;
        u4.i_Enable = 0; u4.i_Mode = 0; u4.i_Start = 0;
        u4.i_Burst_Len = '0; u4.i_Seed_DV = 0; u4.i_Seed_Data = '0;
        u4s.i_Enable = 0; u4s.i_Mode = 0; u4s.i_Start = 0;
        u4s.i_Burst_Len = '0; u4s.i_Seed_DV = 0; u4s.i_Seed_Data = '0;
        #1 rst_n = 1'b0;
        #20;
        chk("reset16", pk(32'(u16.o_LFSR_Data), u16.o_LFSR_DV,
                          u16.o_LFSR_Done, 32'(u16.o_Period_Cnt), u16.o_Busy,
                          u16.o_Burst_Done, u16.o_Seed_Err), '0);
        chk("reset4", pk(32'(u4.o_LFSR_Data), u4.o_LFSR_DV, u4.o_LFSR_Done,
                         32'(u4.o_Period_Cnt), u4.o_Busy, u4.o_Burst_Done,
                         u4.o_Seed_Err), '0);
        rst_n = 1'b1;

        // 4-bit free-run: full period of 15 advances
        u4.i_Enable = 1;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("t1_data", 70'(u4.o_LFSR_Data), 70'(seq4[k]));
            chk("t1_cnt", 70'(u4.o_Period_Cnt), (k < 14) ? 70'(k + 1) : 70'd0);
            chk("t1_done", 70'(u4.o_LFSR_Done), (k == 14) ? 70'd1 : 70'd0);
        end
        u4.i_Enable = 0;

        // 16-bit free-run over the whole period
        ndone = 0;
        u16.i_Enable = 1;
        for (int k = 0; k < 65535; k++) begin
            tick();
            ndone += int'(u16.o_LFSR_Done);
        end
        u16.i_Enable = 0;
        chk("t2_data", 70'(u16.o_LFSR_Data), 70'h0);
        chk("t2_ndone", 70'(ndone), 70'd1);
        chk("t2_cnt", 70'(u16.o_Period_Cnt), 70'd0);

        // Burst of 5 with one stall cycle
        dv_n = 0; busy_n = 0; bd_n = 0; last_dv = -1; bd_at = -1;
        u16.i_Mode = 1; u16.i_Burst_Len = 16'd5; u16.i_Start = 1;
        for (int k = 0; k < 12; k++) begin
            u16.i_Enable = (k < 7) ? en_pat[k] : 1'b1;
            tick();
            u16.i_Start = 0;
            if (u16.o_LFSR_DV) begin
                dv_n++;
                last_dv = k;
            end
            busy_n += int'(u16.o_Busy);
            if (u16.o_Burst_Done) begin
                bd_n++;
                bd_at = k;
            end
        end
        chk("t3_dv_n", 70'(dv_n), 70'd5);
        chk("t3_busy_n", 70'(busy_n), 70'd7);
        chk("t3_bd_n", 70'(bd_n), 70'd1);
        chk("t3_last_dv", 70'(last_dv), 70'd6);
        chk("t3_bd_at", 70'(bd_at), 70'd6);

        // Zero-length burst completes at once
        u16.i_Burst_Len = 16'd0; u16.i_Start = 1;
        tick();
        u16.i_Start = 0;
        chk("t3z_bd", 70'({u16.o_Busy, u16.o_Burst_Done, u16.o_LFSR_DV}),
            70'b110);
        tick();
        chk("t3z_idle", 70'({u16.o_Busy, u16.o_Burst_Done}), 70'b00);

        // Seed load aborts an active burst
        u16.i_Burst_Len = 16'd10; u16.i_Start = 1; u16.i_Enable = 1;
        tick();
        u16.i_Start = 0;
        tick();
        tick();
        u16.i_Seed_DV = 1; u16.i_Seed_Data = 16'h1234;
        tick();
        u16.i_Seed_DV = 0; u16.i_Enable = 0;
        chk("t4_data", 70'(u16.o_LFSR_Data), 70'h1234);
        chk("t4_busy", 70'(u16.o_Busy), 70'd0);
        chk("t4_bd", 70'(u16.o_Burst_Done), 70'd0);
        chk("t4_cnt", 70'(u16.o_Period_Cnt), 70'd0);
        bd_n = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            bd_n += int'(u16.o_Burst_Done);
        end
        chk("t4_no_bd", 70'(bd_n), 70'd0);

        // All-ones seed
        u16.i_Seed_DV = 1; u16.i_Seed_Data = 16'hFFFF;
        tick();
        u16.i_Seed_DV = 0;
`ifdef LFSR_SEED_CHECK_EN
        chk("t5_data", 70'(u16.o_LFSR_Data), 70'h0000);
        chk("t5_err", 70'(u16.o_Seed_Err), 70'd1);
`else
        chk("t5_data", 70'(u16.o_LFSR_Data), 70'hFFFF);
        chk("t5_err", 70'(u16.o_Seed_Err), 70'd0);
`endif
        u16.i_Mode = 0; u16.i_Enable = 1;
        tick();
        chk("t5_err_end", 70'(u16.o_Seed_Err), 70'd0);
        tick();
        u16.i_Enable = 0;
`ifdef LFSR_SEED_CHECK_EN
        chk("t5_run", 70'(u16.o_LFSR_Data), 70'h0003);
`else
        chk("t5_lock", 70'(u16.o_LFSR_Data), 70'hFFFF);
`endif

        // Four steps per advance, then reset in the middle of a burst
        u16.i_Mode = 1; u16.i_Burst_Len = 16'd20; u16.i_Start = 1;
        u16.i_Enable = 1;
        tick();
        u16.i_Start = 0;
        u4s.i_Enable = 1;
        tick();
        chk("t6_d1", 70'(u4s.o_LFSR_Data), 70'hE);
        tick();
        chk("t6_d2", 70'(u4s.o_LFSR_Data), 70'hC);
        tick();
        chk("t6_d3", 70'(u4s.o_LFSR_Data), 70'hA);
        chk("t6_busy", 70'(u16.o_Busy), 70'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst4s", pk(32'(u4s.o_LFSR_Data), u4s.o_LFSR_DV,
                           u4s.o_LFSR_Done, 32'(u4s.o_Period_Cnt),
                           u4s.o_Busy, u4s.o_Burst_Done, u4s.o_Seed_Err), '0);
        chk("t6_rst16", pk(32'(u16.o_LFSR_Data), u16.o_LFSR_DV,
                           u16.o_LFSR_Done, 32'(u16.o_Period_Cnt),
                           u16.o_Busy, u16.o_Burst_Done, u16.o_Seed_Err), '0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        u4s.i_Enable = 0;
        bd_n = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            bd_n += int'(u16.o_Burst_Done) + int'(u16.o_Busy);
        end
        chk("t6_no_bd", 70'(bd_n), 70'd0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
